frame_gen: RTL and testbench

//   Transmit-side packet framer; the counterpart of the receive-side frame checker.

---
 rtl/frame_gen.sv | 97 +++++++++
 tb/tb_frame_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_gen.sv
// frame_gen: transmit framer that buffers payload words in a show-ahead FIFO and emits
// header / PAYLOAD_WORDS payload / tail packets, with idle fill between packets.
module frame_gen #(
    parameter int                DATA_W        = 62,
    parameter int                PAYLOAD_WORDS = 25,
    parameter int                FIFO_DEPTH    = 32,
    parameter logic [DATA_W-1:0] HEADER_WORD   = '0,
    parameter logic [DATA_W-1:0] IDLE_WORD     = '0,
    parameter logic [3:0]        TAIL_CODE     = 4'b0011
) (
    input  logic                          clk_390p625M,
    input  logic                          rst_n,
    input  logic                          tx_enable,
    input  logic                          force_tail_error,
    input  logic [DATA_W-1:0]             payload_data,
    input  logic                          payload_valid,
    output logic                          payload_ready,
    output logic [DATA_W-1:0]             unscrambled_data,
    output logic                          data_packet_start,
    output logic [29:0]                   packet_count,
    output logic                          packet_count_wrap,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(PAYLOAD_WORDS + 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TAIL} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q;
    logic [29:0]       count_q;
    logic              wrap_q;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              push, pop, go;

    assign push = payload_valid && payload_ready;
    assign pop  = state_q == PAYLOAD;
    // Starting only with a full packet buffered means payload can never run dry mid-packet.
    assign go   = tx_enable && level_q >= (AW+1)'(PAYLOAD_WORDS);

    always_ff @(posedge clk_390p625M) begin
        if (push) mem_q[wr_ptr_q] <= payload_data;
    end

    always_ff @(posedge clk_390p625M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q  <= level_q + (AW+1)'(push) - (AW+1)'(pop);
            if (state_q == HEADER) count_q <= count_q + 30'd1;
            wrap_q   <= state_q == HEADER && &count_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE:    state_d = go ? HEADER : IDLE;
            HEADER: begin
                state_d = PAYLOAD;
                idx_d   = IW'(1);
            end
            PAYLOAD: begin
                state_d = idx_q == IW'(PAYLOAD_WORDS) ? TAIL : PAYLOAD;
                idx_d   = idx_q + IW'(1);
            end
            TAIL:    state_d = go ? HEADER : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unscrambled_data = state_q == HEADER  ? HEADER_WORD :
                           state_q == PAYLOAD ? mem_q[rd_ptr_q] :
                           state_q == TAIL    ? {{(DATA_W-34){1'b0}}, count_q, TAIL_CODE ^ {4{force_tail_error}}} :
                                                IDLE_WORD;
    end

    assign data_packet_start = state_q == HEADER;
    assign payload_ready     = level_q != (AW+1)'(FIFO_DEPTH);
    assign packet_count      = count_q;
    assign packet_count_wrap = wrap_q;
    assign fifo_level        = level_q;
endmodule

// File: tb/tb_frame_gen.sv
// tb_frame_gen: directed stimulus for frame_gen; expected packets go into a queue that a
// separate negedge monitor drains while comparing the framed output stream.
module tb_frame_gen;
    logic        clk = 1'b0;
    logic        rst_n, tx_enable, force_tail_error, payload_valid;
    logic [61:0] payload_data;
    logic        payload_ready, data_packet_start, packet_count_wrap;
    logic [61:0] unscrambled_data;
    logic [29:0] packet_count;
    logic [5:0]  fifo_level;

    logic [61:0] exp_q[$];
    int          n_chk = 0, n_pass = 0, rem = 0;

    frame_gen dut (
        .clk_390p625M      (clk),
        .rst_n             (rst_n),
        .tx_enable         (tx_enable),
        .force_tail_error  (force_tail_error),
        .payload_data      (payload_data),
        .payload_valid     (payload_valid),
        .payload_ready     (payload_ready),
        .unscrambled_data  (unscrambled_data),
        .data_packet_start (data_packet_start),
        .packet_count      (packet_count),
        .packet_count_wrap (packet_count_wrap),
        .fifo_level        (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [61:0] tail_word(input logic [29:0] cnt, input logic err);
        return {28'b0, cnt, 4'b0011 ^ {4{err}}};
    endfunction

    task automatic expect_packet(input int base, input logic [29:0] cnt, input logic err);
        exp_q.push_back(62'h0);
        for (int i = 0; i < 25; i++) exp_q.push_back(62'(base + i));
        exp_q.push_back(tail_word(cnt, err));
    endtask

    task automatic push_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            payload_data  = 62'(first + i);
            payload_valid = 1'b1;
            tick();
        end
        payload_valid = 1'b0;
    endtask

    task automatic do_reset();
        payload_valid = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: a header opens a 27-word window compared against the queue; outside it, idle fill.
    always @(negedge clk) begin
        if (!rst_n) begin
            rem = 0;
            exp_q.delete();
        end else begin
            if (rem == 0 && data_packet_start) rem = 27;
            if (rem == 0) check("idle_word", 64'(unscrambled_data), 64'h0);
            else begin
                if (rem != 27) check("start_mid_packet", 64'(data_packet_start), 64'h0);
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got %h with nothing expected at %0t", unscrambled_data, $time);
                end else check("stream_word", 64'(unscrambled_data), 64'(exp_q.pop_front()));
                rem--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic acc;
        rst_n = 1'b0; tx_enable = 1'b0; force_tail_error = 1'b0;
        payload_valid = 1'b0; payload_data = '0;
        tick(2);
        check("rst_data", 64'(unscrambled_data), 64'h0);
        check("rst_start", 64'(data_packet_start), 64'h0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ready", 64'(payload_ready), 64'd1);
        check("rst_count", 64'(packet_count), 64'd0);
        check("rst_wrap", 64'(packet_count_wrap), 64'd0);
        rst_n = 1'b1;
        tick();

        // T1: single packet
        tx_enable = 1'b1;
        expect_packet(1, 30'd1, 1'b0);
        push_words(1, 25);
        check("t1_level25", 64'(fifo_level), 64'd25);
        check("t1_no_start_yet", 64'(data_packet_start), 64'd0);
        tick();
        check("t1_header", 64'(data_packet_start), 64'd1);
        tick(26);
        check("t1_tail", 64'(unscrambled_data), 64'(tail_word(30'd1, 1'b0)));
        tick();
        check("t1_idle_after", 64'(unscrambled_data), 64'h0);
        check("t1_level0", 64'(fifo_level), 64'd0);
        check("t1_count", 64'(packet_count), 64'd1);

        // T2: back-to-back packets
        do_reset();
        expect_packet(101, 30'd1, 1'b0);
        expect_packet(126, 30'd2, 1'b0);
        push_words(101, 50);
        tick(2);
        check("t2_tail1", 64'(unscrambled_data), 64'(tail_word(30'd1, 1'b0)));
        tick();
        check("t2_b2b_header", 64'(data_packet_start), 64'd1);
        tick(26);
        check("t2_tail2", 64'(unscrambled_data), 64'(tail_word(30'd2, 1'b0)));
        tick();
        check("t2_idle_start", 64'(data_packet_start), 64'd0);
        check("t2_level0", 64'(fifo_level), 64'd0);

        // T3: threshold and tx_enable gating
        do_reset();
        push_words(201, 24);
        for (int i = 0; i < 4; i++) begin
            check("t3_no_start_24", 64'(data_packet_start), 64'd0);
            tick();
        end
        check("t3_level24", 64'(fifo_level), 64'd24);
        expect_packet(201, 30'd1, 1'b0);
        push_words(225, 1);
        check("t3_start_not_yet", 64'(data_packet_start), 64'd0);
        tick();
        check("t3_header", 64'(data_packet_start), 64'd1);
        tick(27);
        tx_enable = 1'b0;
        push_words(230, 25);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_disabled_no_start", 64'(data_packet_start), 64'd0);
        end
        check("t3_level25_held", 64'(fifo_level), 64'd25);

        // T4: tail error hook
        do_reset();
        tx_enable = 1'b1;
        force_tail_error = 1'b1;
        expect_packet(301, 30'd1, 1'b1);
        push_words(301, 25);
        tick(27);
        check("t4_tail_err", 64'(unscrambled_data[3:0]), 64'hC);
        tick();
        force_tail_error = 1'b0;
        expect_packet(326, 30'd2, 1'b0);
        push_words(326, 25);
        tick(27);
        check("t4_tail_ok", 64'(unscrambled_data[3:0]), 64'h3);
        tick();

        // T5: backpressure when full
        do_reset();
        tx_enable = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            payload_data  = 62'(401 + n);
            payload_valid = 1'b1;
            acc = payload_ready;
            tick();
            if (acc) n++;
        end
        payload_valid = 1'b0;
        check("t5_accepted", 64'(n), 64'd32);
        check("t5_ready_low", 64'(payload_ready), 64'd0);
        check("t5_level32", 64'(fifo_level), 64'd32);
        expect_packet(401, 30'd1, 1'b0);
        tx_enable = 1'b1;
        tick();
        check("t5_header", 64'(data_packet_start), 64'd1);
        tick(26);
        check("t5_level_at_tail", 64'(fifo_level), 64'd7);
        tick();
        check("t5_no_second", 64'(data_packet_start), 64'd0);
        expect_packet(426, 30'd2, 1'b0);
        push_words(433, 18);
        tick();
        check("t5_header2", 64'(data_packet_start), 64'd1);
        tick(27);
        check("t5_level0", 64'(fifo_level), 64'd0);

        // T6: reset mid-packet, then counter wrap
        do_reset();
        tx_enable = 1'b1;
        expect_packet(501, 30'd1, 1'b0);
        push_words(501, 25);
        tick();
        tick(10);
        check("t6_word10", 64'(unscrambled_data), 64'd510);
        rst_n = 1'b0;
        tick();
        check("t6_rst_data", 64'(unscrambled_data), 64'h0);
        check("t6_rst_start", 64'(data_packet_start), 64'd0);
        check("t6_rst_level", 64'(fifo_level), 64'd0);
        check("t6_rst_count", 64'(packet_count), 64'd0);
        rst_n = 1'b1;
        tick();
        force dut.count_q = 30'h3FFF_FFFF;
        tick();
        release dut.count_q;
        tick();
        check("t6_preload", 64'(packet_count), 64'h3FFF_FFFF);
        expect_packet(601, 30'd0, 1'b0);
        push_words(601, 25);
        check("t6_wrap_idle", 64'(packet_count_wrap), 64'd0);
        tick();
        check("t6_header", 64'(data_packet_start), 64'd1);
        check("t6_wrap_hdr", 64'(packet_count_wrap), 64'd0);
        tick();
        check("t6_count_wrapped", 64'(packet_count), 64'd0);
        check("t6_wrap_pulse", 64'(packet_count_wrap), 64'd1);
        tick();
        check("t6_wrap_cleared", 64'(packet_count_wrap), 64'd0);
        tick(25);
        check("t6_idle_after", 64'(data_packet_start), 64'd0);

        tick(5);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
